// File: rtl/clock_pkg.sv
// +--------------------------------------------------------------------------+
// | Package     : clock_pkg                                                  |
// | Description : Shared constants and types for the button input path:     |
// |               button channel indices, channel FSM states and default     |
// |               cycle counts for a 10 kHz clock.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package clock_pkg;

    // Channel index of each physical button
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_MODE   = 2;
    localparam int BTN_ADJUST = 3;

    // Defaults for a 10 kHz clock
    localparam int N_BTN_DEFAULT    = 4;
    localparam int DB_CYC_DEFAULT   = 200;   // 20 ms
    localparam int LONG_CYC_DEFAULT = 8000;  // 800 ms
    localparam int REP_CYC_DEFAULT  = 1000;  // 100 ms

    // Per-channel press state
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_PRESS = 2'd1,
        CH_HELD  = 2'd2
    } ch_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// +--------------------------------------------------------------------------+
// | Module      : btn_channel                                                |
// | Description : One push-button: 2-flop synchronizer, debounce, press /    |
// |               release pulses, long-press detect and auto-repeat.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_channel
    import clock_pkg::*;
#(
    parameter int DB_CYC   = DB_CYC_DEFAULT,
    parameter int LONG_CYC = LONG_CYC_DEFAULT,
    parameter int REP_CYC  = REP_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic rep_en_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o
);

    localparam int DB_W   = cnt_width(DB_CYC + 1);
    localparam int HOLD_W = cnt_width(LONG_CYC);
    localparam int REP_W  = cnt_width(REP_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);

    logic [1:0]        sync_q;
    logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
    logic              level_q,   level_d;
    ch_state_e         state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [REP_W-1:0]  rep_q,     rep_d;
    logic              press_q,   press_d;
    logic              release_q, release_d;
    logic              long_q,    long_d;
    logic              repeat_q,  repeat_d;
    logic              db_toggle;

    // Next-state: debounce counter, debounced level, press FSM and pulse generation
    always_comb begin
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        db_toggle = 1'b0;

        // Count consecutive cycles where the synchronized input disagrees
        // with the debounced level; the DB_CYC-th such cycle flips the level.
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_cnt_d  = '0;
                level_d   = ~level_q;
                db_toggle = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end

        press_d   = db_toggle & ~level_q;
        release_d = db_toggle &  level_q;

        unique case (state_q)
            CH_IDLE: begin
                if (press_d) begin
                    state_d = CH_PRESS;
                    hold_d  = '0;
                end
            end
            CH_PRESS: begin
                // A release wins over a long pulse due in the same cycle
                if (release_d) begin
                    state_d = CH_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d  = CH_HELD;
                    long_d   = 1'b1;
                    repeat_d = rep_en_i;
                    rep_d    = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            CH_HELD: begin
                // hold_q stays saturated; the repeat phase runs even with rep_en low
                if (release_d) begin
                    state_d = CH_IDLE;
                end else if (rep_q == REP_LAST) begin
                    rep_d    = '0;
                    repeat_d = rep_en_i;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
            default: begin
                state_d = CH_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= CH_IDLE;
            hold_q    <= '0;
            rep_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign btn_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign repeat_pulse_o  = repeat_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// +--------------------------------------------------------------------------+
// | Module      : button_conditioner                                         |
// | Description : Conditions N_BTN raw push-buttons into debounced levels    |
// |               and single-cycle press/release/long/repeat events.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module button_conditioner
    import clock_pkg::*;
#(
    parameter int N_BTN    = N_BTN_DEFAULT,
    parameter int DB_CYC   = DB_CYC_DEFAULT,
    parameter int LONG_CYC = LONG_CYC_DEFAULT,
    parameter int REP_CYC  = REP_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw_i,
    input  logic [N_BTN-1:0] rep_en_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] press_pulse_o,
    output logic [N_BTN-1:0] release_pulse_o,
    output logic [N_BTN-1:0] long_pulse_o,
    output logic [N_BTN-1:0] repeat_pulse_o
);

    // One fully independent channel per button
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC)
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .btn_raw_i       (btn_raw_i[i]),
            .rep_en_i        (rep_en_i[i]),
            .btn_level_o     (btn_level_o[i]),
            .press_pulse_o   (press_pulse_o[i]),
            .release_pulse_o (release_pulse_o[i]),
            .long_pulse_o    (long_pulse_o[i]),
            .repeat_pulse_o  (repeat_pulse_o[i])
        );
    end

endmodule

`default_nettype wire
